tca9539_i2c_master: RTL and testbench
=====================================

// Module: tca9539_i2c_master
// PURPOSE
//  I2C controller (initiator) for TCA9539-class 16-bit GPIO expanders. It runs a single register
//  write or read per request, from a simple start/ready/done host interface, onto an open-drain bus.
//  It sits between the system-side register client and the expander's scl/sda pins.
//  Target address is 7'b11101_{a1,a0}. Single master; no clock stretching; no arbitration.
// PARAMETERS
//  CLK_DIV   250   clk cycles per SCL quarter-period (min 2); SCL period = 4*CLK_DIV clk cycles
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  reset      in   1   synchronous, active-high reset
//  start      in   1   request strobe; accepted only when ready=1
//  ready      out  1   idle, can accept start
//  rw         in   1   0 = register write, 1 = register read
//  dev_addr   in   2   {a1,a0} of target
//  cmd        in   3   command byte low bits (byte sent = {5'b0,cmd})
//  two_bytes  in   1   1 = transfer 2 data bytes (cmd, then cmd^1 via target auto-increment)
//  wdata      in   16  write data; byte0 = wdata[7:0], byte1 = wdata[15:8]
//  rdata      out  16  read data; byte0 -> rdata[7:0], byte1 -> rdata[15:8]; unused byte = 0
//  done       out  1   1-cycle pulse at end of transaction
//  ack_err    out  1   valid with done: 1 = target NACKed a master-sent byte
//  scl_oe     out  1   1 = pull SCL low; 0 = release
//  sda_oe     out  1   1 = pull SDA low; 0 = release
//  sda_i      in   1   sampled SDA line level
// BEHAVIOUR
//  Reset: scl_oe=0, sda_oe=0, ready=1, done=0, ack_err=0, rdata=0, FSM=IDLE. Takes effect mid-transfer.
//   The bus is released with no STOP. The next transfer begins normally.
//  Accept: start&&ready latches rw/dev_addr/cmd/two_bytes/wdata. ready drops the next cycle.
//   start while ready=0 is ignored. rdata is cleared on accept.
//  Quarter tick: counter 0..CLK_DIV-1. Every bus slot is 4 quarters q0..q3.
//  START / Sr slot: q0 SCL low, SDA released; q1 SCL released; q2 SDA low; q3 SCL low.
//  Bit slot: q0 SCL low, SDA set to bit (release for 1 / ACK-receive / read bits);
//   q1-q2 SCL released; sample sda_i on last clk of q2; q3 SCL low.
//  STOP slot: q0 SCL low, SDA low; q1 SCL released; q2-q3 SDA released.
//  Bytes are MSB first, each followed by a 9th ACK bit (ACK = SDA low).
//  FSM: IDLE -> START -> ADDR -> A1 -> CMD -> A2 -> then by operation:
//   write: WDATA -> A3 [-> WDATA -> A3] -> STOP
//   read:  RSTART -> ADDR_R -> A4 -> RDATA -> MACK [-> RDATA -> MACK] -> STOP
//   STOP -> IDLE
//  ADDR byte = {7'b11101,a1,a0,0}. ADDR_R byte = {7'b11101,a1,a0,1}.
//  Master drives ACK (low) after every read byte except the last, which gets NACK (released).
//  NACK (sda_i=1) sampled in A1..A4: go to STOP after the ACK slot and set ack_err.
//   No further bytes are sent.
//  done: pulses on the clk after STOP q3 ends, with ack_err valid. ready=1 in that same cycle.
//   ack_err holds until the next accept.
//  Latency: done is N*4*CLK_DIV clk after the accept edge, where N = slot count.
//   write: N = 2+9*(2+nb). read: N = 3+9*(3+nb). nb = two_bytes?2:1.
//  SCL high time 2 quarters. SDA changes only while SCL low, except in START/Sr/STOP.
// TESTING
//  1. CLK_DIV=4, dev_addr=2'b01, write, cmd=3'b010, two_bytes=1, wdata=16'hA55A, BFM ACKs all
//     -> bus bytes 0xEA,0x02,0x5A,0xA5; START/STOP legal; done at 38*16 clk; ack_err=0.
//  2. Read, dev_addr=0, cmd=0, two_bytes=1, BFM returns 0x12 then 0x34
//     -> 0xE8,0x00,Sr,0xE9; master ACK then NACK; rdata=16'h3412; done at 48*16 clk.
//  3. Write with BFM NACKing the address
//     -> STOP immediately after A1; no CMD byte on bus; done with ack_err=1; ready=1.
//  4. reset asserted mid-CMD byte -> scl_oe=sda_oe=0 on the next cycle; ready=1; no done.
//     A following write completes normally.
//  5. start pulsed repeatedly while busy -> ignored; exactly one transaction and one done pulse.
//  6. Read, two_bytes=0, BFM returns 0x5C -> rdata=16'h005C; single byte NACKed; done at 39*16 clk.

Source files
------------

// File: rtl/tca9539_i2c_master.sv
// I2C initiator for TCA9539-class GPIO expanders: one register write or read per request.
// Every bus slot is four quarter-periods; scl_oe/sda_oe are open-drain pull-down enables.
module tca9539_i2c_master #(
  parameter int CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        ready,
  input  logic        rw,
  input  logic [1:0]  dev_addr,
  input  logic [2:0]  cmd,
  input  logic        two_bytes,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        done,
  output logic        ack_err,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i
);

  localparam int            CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] QMAX       = CW'(CLK_DIV - 1);
  localparam logic [4:0]    DEV_PREFIX = 5'b11101;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_A1,
    S_CMD,
    S_A2,
    S_WDATA,
    S_A3,
    S_RSTART,
    S_ADDR_R,
    S_A4,
    S_RDATA,
    S_MACK,
    S_STOP
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] qcnt_reg;
  logic [1:0]    quarter_reg;
  logic [2:0]    bit_cnt_reg;
  logic          byte_idx_reg;
  logic          ack_bit_reg;
  logic [7:0]    rx_shift_reg;
  logic          rw_reg;
  logic          two_reg;
  logic [1:0]    dev_reg;
  logic [2:0]    cmd_reg;
  logic [15:0]   wdata_reg;
  logic          done_reg;
  logic          ack_err_reg;

  logic       accept;
  logic       tick;
  logic       sample;
  logic       slot_end;
  logic       byte_done;
  logic       last_byte;
  logic       bit_scl;
  logic       is_byte_state;
  logic       is_ack_state;
  logic [7:0] tx_byte;

  assign accept    = (state_reg == S_IDLE) && start;
  assign tick      = (qcnt_reg == QMAX);
  assign sample    = tick && (quarter_reg == 2'd2);
  assign slot_end  = tick && (quarter_reg == 2'd3);
  assign byte_done = slot_end && (bit_cnt_reg == 3'd7);
  assign last_byte = !two_reg || byte_idx_reg;
  // In a bit slot SCL is held low in q0 and q3, released in q1-q2.
  assign bit_scl   = (quarter_reg == 2'd0) || (quarter_reg == 2'd3);

  assign is_byte_state = (state_reg == S_ADDR) || (state_reg == S_CMD) || (state_reg == S_WDATA) ||
                         (state_reg == S_ADDR_R) || (state_reg == S_RDATA);
  assign is_ack_state  = (state_reg == S_A1) || (state_reg == S_A2) ||
                         (state_reg == S_A3) || (state_reg == S_A4);

  assign ready   = (state_reg == S_IDLE);
  assign done    = done_reg;
  assign ack_err = ack_err_reg;

  always_comb begin
    tx_byte = 8'h00;
    case (state_reg)
      S_ADDR:   tx_byte = {DEV_PREFIX, dev_reg, 1'b0};
      S_CMD:    tx_byte = {5'b00000, cmd_reg};
      S_WDATA:  tx_byte = byte_idx_reg ? wdata_reg[15:8] : wdata_reg[7:0];
      S_ADDR_R: tx_byte = {DEV_PREFIX, dev_reg, 1'b1};
      default:  tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    scl_oe     = 1'b0;
    sda_oe     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_START;
      end
      S_START, S_RSTART: begin
        scl_oe = bit_scl;
        sda_oe = quarter_reg[1];
        if (slot_end) state_next = (state_reg == S_START) ? S_ADDR : S_ADDR_R;
      end
      S_ADDR, S_CMD, S_WDATA, S_ADDR_R: begin
        scl_oe = bit_scl;
        sda_oe = !tx_byte[3'd7 - bit_cnt_reg];
        if (byte_done) begin
          case (state_reg)
            S_ADDR:  state_next = S_A1;
            S_CMD:   state_next = S_A2;
            S_WDATA: state_next = S_A3;
            default: state_next = S_A4;
          endcase
        end
      end
      S_A1, S_A2, S_A3, S_A4: begin
        scl_oe = bit_scl;
        if (slot_end) begin
          // A NACK from the target aborts straight to STOP; nothing more is sent.
          if (ack_bit_reg) begin
            state_next = S_STOP;
          end else begin
            case (state_reg)
              S_A1:    state_next = S_CMD;
              S_A2:    state_next = rw_reg ? S_RSTART : S_WDATA;
              S_A3:    state_next = last_byte ? S_STOP : S_WDATA;
              default: state_next = S_RDATA;
            endcase
          end
        end
      end
      S_RDATA: begin
        scl_oe = bit_scl;
        if (byte_done) state_next = S_MACK;
      end
      S_MACK: begin
        scl_oe = bit_scl;
        sda_oe = !last_byte;
        if (slot_end) state_next = last_byte ? S_STOP : S_RDATA;
      end
      S_STOP: begin
        scl_oe = (quarter_reg == 2'd0);
        sda_oe = !quarter_reg[1];
        if (slot_end) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || accept || (state_reg == S_IDLE)) begin
      qcnt_reg    <= '0;
      quarter_reg <= 2'd0;
    end else if (tick) begin
      qcnt_reg    <= '0;
      quarter_reg <= quarter_reg + 2'd1;
    end else begin
      qcnt_reg    <= qcnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_reg  <= 3'd0;
      byte_idx_reg <= 1'b0;
      ack_bit_reg  <= 1'b0;
      rx_shift_reg <= 8'h00;
      done_reg     <= 1'b0;
      ack_err_reg  <= 1'b0;
    end else begin
      done_reg <= (state_reg == S_STOP) && slot_end;
      if (accept) begin
        bit_cnt_reg  <= 3'd0;
        byte_idx_reg <= 1'b0;
        ack_err_reg  <= 1'b0;
      end else begin
        // The 3-bit counter wraps to 0 after bit 7, ready for the next byte.
        if (slot_end && is_byte_state) bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (slot_end && (((state_reg == S_A3) && !ack_bit_reg) || (state_reg == S_MACK)))
          byte_idx_reg <= 1'b1;
        if (slot_end && is_ack_state && ack_bit_reg) ack_err_reg <= 1'b1;
      end
      if (sample) ack_bit_reg <= sda_i;
      if (sample && (state_reg == S_RDATA)) rx_shift_reg <= {rx_shift_reg[6:0], sda_i};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rw_reg    <= rw;
      two_reg   <= two_bytes;
      dev_reg   <= dev_addr;
      cmd_reg   <= cmd;
      wdata_reg <= wdata;
    end
  end

  // Each read byte lands in its own half of rdata once its eighth bit has been sampled.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rbyte
    logic [7:0] byte_reg;
    always_ff @(posedge clk) begin
      if (reset || accept) begin
        byte_reg <= 8'h00;
      end else if ((state_reg == S_RDATA) && byte_done && (byte_idx_reg == 1'(gi))) begin
        byte_reg <= rx_shift_reg;
      end
    end
    assign rdata[gi*8 +: 8] = byte_reg;
  end

endmodule

// File: tb/tb_tca9539_i2c_master.sv
// Bench for tca9539_i2c_master: an I2C target model logs bus events into a scoreboard queue
// and returns read data; host-side results are compared per transaction.
module tb_tca9539_i2c_master;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  dev_addr = 2'b00;
  logic [2:0]  cmd = 3'b000;
  logic        two_bytes = 1'b0;
  logic [15:0] wdata = 16'h0000;
  logic        ready, done, ack_err, scl_oe, sda_oe;
  logic [15:0] rdata;
  logic        bfm_low = 1'b0;
  logic        scl, sda;

  assign scl = ~scl_oe;
  assign sda = ~(sda_oe | bfm_low);

  always #5 clk = ~clk;

  tca9539_i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .rw(rw),
    .dev_addr(dev_addr), .cmd(cmd), .two_bytes(two_bytes), .wdata(wdata),
    .rdata(rdata), .done(done), .ack_err(ack_err), .scl_oe(scl_oe),
    .sda_oe(sda_oe), .sda_i(sda)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned done_cnt = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  rd_q[$];

  // Bus event codes: 0x0xx master-sent byte, 0x100 START, 0x101 STOP, 0x102 master ACK, 0x103 master NACK.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic bfm_event(input logic [8:0] code);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      check_eq("bus_unexpected", {23'd0, code}, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check_eq("bus_event", {23'd0, code}, {23'd0, e});
    end
  endtask

  always @(negedge clk) if (done) done_cnt++;

  // Target model, sampled on the falling clk edge away from DUT updates.
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       bfm_act = 1'b0, bfm_tx = 1'b0, rd_mode = 1'b0, first_byte = 1'b0;
  logic       m_nack = 1'b0, skip_fall = 1'b0, nack_addr = 1'b0;
  int         bitn = 0;
  logic [7:0] shift = 8'h00, tx_byte = 8'h00;

  always @(negedge clk) begin
    logic s_scl, s_sda;
    s_scl = scl;
    s_sda = sda;
    if (reset) begin
      bfm_act = 1'b0; bfm_tx = 1'b0; rd_mode = 1'b0; bfm_low = 1'b0;
    end else if (s_scl && prev_scl && prev_sda && !s_sda) begin
      bfm_event(9'h100);
      bfm_act = 1'b1; bfm_tx = 1'b0; rd_mode = 1'b0; first_byte = 1'b1;
      bitn = 0; shift = 8'h00; bfm_low = 1'b0; skip_fall = 1'b1;
    end else if (s_scl && prev_scl && !prev_sda && s_sda) begin
      bfm_event(9'h101);
      bfm_act = 1'b0; bfm_tx = 1'b0; bfm_low = 1'b0;
    end else if (bfm_act && s_scl && !prev_scl) begin
      if (bitn < 8) begin
        if (!bfm_tx) begin
          shift = {shift[6:0], s_sda};
          if (bitn == 7) begin
            bfm_event({1'b0, shift});
            if (first_byte) rd_mode = shift[0];
          end
        end
      end else if (bfm_tx) begin
        bfm_event(s_sda ? 9'h103 : 9'h102);
        m_nack = s_sda;
      end
    end else if (bfm_act && !s_scl && prev_scl) begin
      if (skip_fall) begin
        skip_fall = 1'b0;
      end else if (bitn < 7) begin
        bitn++;
        if (bfm_tx) bfm_low = ~tx_byte[7-bitn];
      end else if (bitn == 7) begin
        bitn = 8;
        bfm_low = !bfm_tx && !(first_byte && nack_addr);
      end else begin
        bitn = 0;
        if (bfm_tx && m_nack) begin
          bfm_tx = 1'b0; bfm_low = 1'b0;
        end else if (rd_mode) begin
          bfm_tx = 1'b1;
          tx_byte = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hFF;
          bfm_low = ~tx_byte[7];
        end else begin
          bfm_low = 1'b0;
        end
        first_byte = 1'b0;
      end
    end
    prev_scl = s_scl;
    prev_sda = s_sda;
  end

  task automatic run_txn(input string name, input logic t_rw, input logic [1:0] t_dev,
                         input logic [2:0] t_cmd, input logic t_two, input logic [15:0] t_wd,
                         input logic t_nack, input logic [7:0] rd0, input logic [7:0] rd1,
                         input int exp_cyc, input logic exp_err, input logic [15:0] exp_rd,
                         input bit spam);
    int n;
    int unsigned d0;
    exp_q.push_back(9'h100);
    exp_q.push_back({1'b0, 5'b11101, t_dev, 1'b0});
    if (t_nack) begin
      exp_q.push_back(9'h101);
    end else begin
      exp_q.push_back({1'b0, 5'b00000, t_cmd});
      if (!t_rw) begin
        exp_q.push_back({1'b0, t_wd[7:0]});
        if (t_two) exp_q.push_back({1'b0, t_wd[15:8]});
      end else begin
        exp_q.push_back(9'h100);
        exp_q.push_back({1'b0, 5'b11101, t_dev, 1'b1});
        rd_q.push_back(rd0);
        if (t_two) begin
          rd_q.push_back(rd1);
          exp_q.push_back(9'h102);
        end
        exp_q.push_back(9'h103);
      end
      exp_q.push_back(9'h101);
    end
    nack_addr = t_nack;
    @(negedge clk);
    rw = t_rw; dev_addr = t_dev; cmd = t_cmd; two_bytes = t_two; wdata = t_wd;
    start = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    check_eq({name, "_ready_busy"}, {31'd0, ready}, 32'd0);
    n = 0;
    while (!done && n < exp_cyc + 200) begin
      @(posedge clk);
      #1;
      n++;
      if (spam) begin
        start = ((n % 37) == 5) && (n < exp_cyc - 20);
        if (start) begin
          rw = ~rw; dev_addr = ~dev_addr; cmd = ~cmd; wdata = ~wdata; two_bytes = ~two_bytes;
        end
      end
    end
    start = 1'b0;
    check_eq({name, "_latency"}, n, exp_cyc);
    check_eq({name, "_ack_err"}, {31'd0, ack_err}, {31'd0, exp_err});
    check_eq({name, "_rdata"}, {16'd0, rdata}, {16'd0, exp_rd});
    check_eq({name, "_ready_done"}, {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1;
    check_eq({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check_eq({name, "_done_count"}, done_cnt - d0, 32'd1);
    check_eq({name, "_bus_pending"}, exp_q.size(), 32'd0);
    nack_addr = 1'b0;
    rd_q.delete();
    $display("[TB] txn %s: rw=%0b dev=%0d cmd=%0d two=%0b cycles=%0d rdata=%04h ack_err=%0b",
             name, t_rw, t_dev, t_cmd, t_two, n, rdata, ack_err);
  endtask

  initial begin
    int unsigned d0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check_eq("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_ack_err", {31'd0, ack_err}, 32'd0);
    check_eq("rst_rdata", {16'd0, rdata}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    run_txn("wr2", 1'b0, 2'b01, 3'b010, 1'b1, 16'hA55A, 1'b0, 8'h00, 8'h00, 38*16, 1'b0, 16'h0000, 1'b0);
    run_txn("rd2", 1'b1, 2'b00, 3'b000, 1'b1, 16'h0000, 1'b0, 8'h12, 8'h34, 48*16, 1'b0, 16'h3412, 1'b0);
    run_txn("wr_nack", 1'b0, 2'b01, 3'b011, 1'b1, 16'hBEEF, 1'b1, 8'h00, 8'h00, 11*16, 1'b1, 16'h0000, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("ack_err_hold", {31'd0, ack_err}, 32'd1);

    // Reset in the middle of the CMD byte: bus released at once, no done.
    exp_q.push_back(9'h100);
    exp_q.push_back({1'b0, 5'b11101, 2'b10, 1'b0});
    @(negedge clk);
    rw = 1'b0; dev_addr = 2'b10; cmd = 3'b011; two_bytes = 1'b0; wdata = 16'h0011;
    start = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (160 + 50) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check_eq("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check_eq("midrst_ready", {31'd0, ready}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check_eq("midrst_no_done", done_cnt - d0, 32'd0);
    check_eq("midrst_bus_pending", exp_q.size(), 32'd0);
    $display("[TB] txn midrst: reset during CMD byte, done_count_delta=%0d", done_cnt - d0);

    run_txn("wr_after_rst", 1'b0, 2'b10, 3'b110, 1'b0, 16'h00C3, 1'b0, 8'h00, 8'h00, 29*16, 1'b0, 16'h0000, 1'b0);
    run_txn("wr_spam", 1'b0, 2'b01, 3'b111, 1'b0, 16'h0077, 1'b0, 8'h00, 8'h00, 29*16, 1'b0, 16'h0000, 1'b1);
    run_txn("rd1", 1'b1, 2'b11, 3'b101, 1'b0, 16'h0000, 1'b0, 8'h5C, 8'h00, 39*16, 1'b0, 16'h005C, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
